// File: rtl/oc8051_rom_fetch_server.sv
// Three-byte instruction-fetch responder with a one-window reuse buffer; N=0..3 reads, resp at T+N+2 (T+1 on full hit).
// Holds response until resp_ready; no request accepted until the current response is consumed.
module oc8051_rom_fetch_server #(
    parameter int ADDR_W   = 16,
    parameter int REUSE_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [7:0]        rom_rdata_0,
    output logic [7:0]        rom_rdata_1,
    output logic [7:0]        rom_rdata_2,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        left_q, left_d;
    logic [1:0]        iss_slot_q, iss_slot_d;
    logic              pend_q, pend_d;
    logic [1:0]        pend_slot_q, pend_slot_d;
    logic [2:0][7:0]   buf_q, buf_d;
    logic [2:0][7:0]   out_q, out_d;
    logic              win_vld_q, win_vld_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [2:0][7:0]   win_q, win_d;
    logic              fl_seen_q, fl_seen_d;

    logic              reuse_ok;
    logic [ADDR_W-1:0] win_off;
    logic [1:0]        n_acc;
    logic [1:0]        first_slot;
    logic [2:0][7:0]   merged;
    logic              last_cap;

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign mem_en      = (state_q == FETCH) && (left_q != 2'd0);
    assign mem_addr    = rd_addr_q;
    assign rom_rdata_0 = out_q[0];
    assign rom_rdata_1 = out_q[1];
    assign rom_rdata_2 = out_q[2];

    // A flush in the accept cycle forces a full fetch.
    assign reuse_ok   = (REUSE_EN != 0) && win_vld_q && !flush;
    assign win_off    = req_addr - win_base_q;
    assign first_slot = 2'd3 - n_acc;
    assign last_cap   = pend_q && (pend_slot_q == 2'd2);

    always_comb begin
        n_acc = 2'd3;
        if (reuse_ok) begin
            if (win_off == ADDR_W'(0)) begin
                n_acc = 2'd0;
            end else if (win_off == ADDR_W'(1)) begin
                n_acc = 2'd1;
            end else if (win_off == ADDR_W'(2)) begin
                n_acc = 2'd2;
            end
        end
    end

    always_comb begin
        merged = buf_q;
        if (pend_q) begin
            merged[pend_slot_q] = mem_rdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_addr_d   = rd_addr_q;
        left_d      = left_q;
        iss_slot_d  = iss_slot_q;
        pend_d      = 1'b0;
        pend_slot_d = pend_slot_q;
        buf_d       = buf_q;
        out_d       = out_q;
        win_vld_d   = win_vld_q;
        win_base_d  = win_base_q;
        win_d       = win_q;
        fl_seen_d   = fl_seen_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    fl_seen_d  = flush;
                    left_d     = n_acc;
                    iss_slot_d = first_slot;
                    rd_addr_d  = req_addr + ADDR_W'(first_slot);
                    // Reused bytes shift down to the slot they occupy relative to the new base.
                    if (n_acc == 2'd1) begin
                        buf_d[0] = win_q[1];
                        buf_d[1] = win_q[2];
                    end else if (n_acc == 2'd2) begin
                        buf_d[0] = win_q[2];
                    end
                    if (n_acc == 2'd0) begin
                        out_d   = win_q;
                        state_d = RESP;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                buf_d       = merged;
                pend_d      = mem_en;
                pend_slot_d = iss_slot_q;
                if (mem_en) begin
                    rd_addr_d  = rd_addr_q + ADDR_W'(1);
                    left_d     = left_q - 2'd1;
                    iss_slot_d = iss_slot_q + 2'd1;
                end
                if (flush) begin
                    fl_seen_d = 1'b1;
                end
                // Slot 2 is always the last byte read, whatever N was.
                if (last_cap) begin
                    out_d   = merged;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush) begin
                    fl_seen_d = 1'b1;
                end
                if (resp_ready) begin
                    win_base_d = addr_q;
                    win_d      = out_q;
                    win_vld_d  = !fl_seen_q && !flush;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            win_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            left_q      <= 2'd0;
            iss_slot_q  <= 2'd0;
            pend_q      <= 1'b0;
            pend_slot_q <= 2'd0;
            buf_q       <= '0;
            out_q       <= '0;
            win_vld_q   <= 1'b0;
            win_base_q  <= '0;
            win_q       <= '0;
            fl_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            left_q      <= left_d;
            iss_slot_q  <= iss_slot_d;
            pend_q      <= pend_d;
            pend_slot_q <= pend_slot_d;
            buf_q       <= buf_d;
            out_q       <= out_d;
            win_vld_q   <= win_vld_d;
            win_base_q  <= win_base_d;
            win_q       <= win_d;
            fl_seen_q   <= fl_seen_d;
        end
    end

endmodule

// File: tb/tb_oc8051_rom_fetch_server.sv
// Bench for oc8051_rom_fetch_server: byte ROM model, expected read addresses and response bytes via queues.
module tb_oc8051_rom_fetch_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  rom_rdata_0, rom_rdata_1, rom_rdata_2;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_sb [$];
    logic [23:0] resp_sb [$];
    int          n_chk = 0;
    int          n_err = 0;

    oc8051_rom_fetch_server #(.ADDR_W(16), .REUSE_EN(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rom_rdata_0(rom_rdata_0),
        .rom_rdata_1(rom_rdata_1),
        .rom_rdata_2(rom_rdata_2),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] ea;
        if (mem_en) begin
            if (addr_sb.size() == 0) begin
                chk("mem_en_unexpected", {31'd0, mem_en}, 32'd0);
            end else begin
                ea = addr_sb.pop_front();
                chk("mem_addr", {16'd0, mem_addr}, {16'd0, ea});
            end
        end
    end

    // fl: 0 none, 1 flush with the accept, 2 flush pulse during RESP (needs hold >= 1)
    task automatic do_req(input logic [15:0] a, input int n, input int hold, input int fl);
        logic [15:0] a1, a2;
        logic [23:0] exp_b, got_b;
        int k, rd;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        resp_sb.push_back({mem[a], mem[a1], mem[a2]});
        for (int i = 3 - n; i < 3; i++) addr_sb.push_back(a + 16'(i));
        req_valid = 1'b1;
        req_addr  = a;
        flush     = (fl == 1);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        k = 1;
        rd = 0;
        while (!resp_valid && k < 20) begin
            rd += int'(mem_en);
            @(negedge clk);
            k++;
        end
        chk("resp_latency", k, (n == 0) ? 1 : n + 2);
        chk("num_reads", rd, n);
        got_b = {rom_rdata_0, rom_rdata_1, rom_rdata_2};
        exp_b = resp_sb.pop_front();
        chk("resp_bytes", {8'd0, got_b}, {8'd0, exp_b});
        resp_ready = 1'b0;
        if (fl == 2) flush = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            flush = 1'b0;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_bytes", {8'd0, rom_rdata_0, rom_rdata_1, rom_rdata_2}, {8'd0, got_b});
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after_consume_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_bytes_held", {8'd0, rom_rdata_0, rom_rdata_1, rom_rdata_2}, {8'd0, got_b});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h0100] = 8'h74; mem[16'h0101] = 8'h5A; mem[16'h0102] = 8'h12;
        mem[16'h0103] = 8'hE4;
        mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h02; mem[16'h0001] = 8'h80;

        rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0; flush = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_rdata", {8'd0, rom_rdata_0, rom_rdata_1, rom_rdata_2}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        do_req(16'h0100, 3, 0, 0);   // cold miss: 74 5A 12
        do_req(16'h0101, 1, 0, 0);   // reuse two bytes, read 0x0103: 5A 12 E4
        do_req(16'h0101, 0, 0, 0);   // full hit, no reads
        do_req(16'h0103, 2, 0, 0);   // base+2: reuse E4, read 0x0104, 0x0105
        do_req(16'hFFFF, 3, 0, 0);   // address wrap
        do_req(16'h0200, 3, 4, 0);   // backpressure
        do_req(16'h0200, 0, 2, 2);   // hit, flushed during RESP
        do_req(16'h0200, 3, 0, 0);   // window invalid after flush
        do_req(16'h0200, 3, 0, 1);   // flush with accept wins over hit
        do_req(16'h0300, 3, 0, 0);

        // reset mid-fetch of a miss: two reads issued, then dropped
        addr_sb.push_back(16'h0400);
        addr_sb.push_back(16'h0401);
        req_valid = 1'b1;
        req_addr  = 16'h0400;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("midrst_rdata", {8'd0, rom_rdata_0, rom_rdata_1, rom_rdata_2}, 32'd0);
        do_req(16'h0300, 3, 0, 0);   // window cleared by reset

        repeat (2) @(negedge clk);
        chk("addr_sb_empty", addr_sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
